// File: rtl/sb_packer_if.sv
// Set-bit field bus from the header writers plus the byte-addressed write port of the packer.
// Handshake: no back-pressure; sb_enable/sb_flush are sampled every clock, wr_en is a one-cycle strobe.
interface sb_packer_if;
    logic        sb_enable;
    logic [63:0] sb_val;
    logic [63:0] sb_size_of_bit;
    logic        sb_flush;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [63:0] wr_data;
    logic [7:0]  wr_byte_en;
    logic [31:0] total_byte_size;
    logic        busy;
    logic        err;

    modport master (
        output sb_enable, sb_val, sb_size_of_bit, sb_flush,
        input  wr_en, wr_addr, wr_data, wr_byte_en, total_byte_size, busy, err
    );

    modport slave (
        input  sb_enable, sb_val, sb_size_of_bit, sb_flush,
        output wr_en, wr_addr, wr_data, wr_byte_en, total_byte_size, busy, err
    );
endinterface

// File: rtl/sb_packer.sv
// Packs MSB-first variable-length bit fields into a big-endian byte stream of 64-bit writes.
// The state is exported on dbg_state (0 = RUN, 1 = TAIL).
module sb_packer #(
    parameter logic [31:0] BASE_ADDR = 32'd0
) (
    input  logic        clock,
    input  logic        reset_n,
    sb_packer_if.slave  bus,
    output logic [0:0]  dbg_state
);
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_TAIL = 1'b1;

    logic [0:0]  state, state_nx;
    logic [63:0] acc, acc_nx;
    logic [5:0]  n, n_nx;
    logic [31:0] next_addr;

    logic [6:0]   size_raw, s, m;
    logic         size_bad, full;
    logic [63:0]  mask, field, rem;
    logic [7:0]   shamt;
    logic [127:0] cat;
    logic [5:0]   r;
    logic [6:0]   rem_r7, tail_r7;
    logic [3:0]   rem_nb, tail_nb;
    logic         unused_size_hi;

    logic        wr_go, busy_nx, err_set;
    logic [63:0] wr_d;
    logic [3:0]  wr_nb;

    assign unused_size_hi = |bus.sb_size_of_bit[63:7];
    assign dbg_state      = state;

    assign size_raw = bus.sb_size_of_bit[6:0];
    assign size_bad = bus.sb_enable && (size_raw > 7'd64);
    assign s        = !bus.sb_enable ? 7'd0 : (size_raw > 7'd64 ? 7'd64 : size_raw);
    assign mask     = (s == 7'd64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << s) - 64'd1);
    assign field    = bus.sb_val & mask;
    assign m        = {1'b0, n} + s;

    // Concatenate pending bits and the new field in a 128-bit window; the top
    // word is complete whenever m reaches 64.
    assign shamt = 8'd128 - {1'b0, m};
    assign cat   = {acc, 64'd0} | ({64'd0, field} << shamt);
    assign full  = m[6];
    assign rem   = full ? cat[63:0] : cat[127:64];
    assign r     = m[5:0];

    assign rem_r7  = {1'b0, r} + 7'd7;
    assign rem_nb  = rem_r7[6:3];
    assign tail_r7 = {1'b0, n} + 7'd7;
    assign tail_nb = tail_r7[6:3];

    always_comb begin
        wr_go    = 1'b0;
        wr_d     = 64'd0;
        wr_nb    = 4'd0;
        acc_nx   = acc;
        n_nx     = n;
        state_nx = state;
        busy_nx  = 1'b0;
        err_set  = 1'b0;
        if (state == ST_TAIL) begin
            wr_go    = 1'b1;
            wr_d     = acc;
            wr_nb    = tail_nb;
            acc_nx   = 64'd0;
            n_nx     = 6'd0;
            state_nx = ST_RUN;
            busy_nx  = 1'b1;
            err_set  = bus.sb_enable | bus.sb_flush;
        end else begin
            err_set = size_bad;
            acc_nx  = rem;
            n_nx    = r;
            if (full) begin
                wr_go = 1'b1;
                wr_d  = cat[127:64];
                wr_nb = 4'd8;
            end
            if (bus.sb_flush) begin
                acc_nx = 64'd0;
                n_nx   = 6'd0;
                if (r != 6'd0) begin
                    // Only one write per cycle: a remainder behind a full word waits a cycle.
                    if (full) begin
                        acc_nx   = rem;
                        n_nx     = r;
                        state_nx = ST_TAIL;
                    end else begin
                        wr_go = 1'b1;
                        wr_d  = rem;
                        wr_nb = rem_nb;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state               <= ST_RUN;
            acc                 <= 64'd0;
            n                   <= 6'd0;
            next_addr           <= BASE_ADDR;
            bus.wr_en           <= 1'b0;
            bus.wr_addr         <= BASE_ADDR;
            bus.wr_data         <= 64'd0;
            bus.wr_byte_en      <= 8'd0;
            bus.total_byte_size <= 32'd0;
            bus.busy            <= 1'b0;
            bus.err             <= 1'b0;
        end else begin
            state          <= state_nx;
            acc            <= acc_nx;
            n              <= n_nx;
            bus.busy       <= busy_nx;
            bus.wr_en      <= wr_go;
            bus.wr_data    <= wr_go ? wr_d : 64'd0;
            bus.wr_byte_en <= wr_go ? ~(8'hFF >> wr_nb) : 8'd0;
            if (err_set) begin
                bus.err <= 1'b1;
            end
            if (wr_go) begin
                bus.wr_addr         <= next_addr;
                next_addr           <= next_addr + {28'd0, wr_nb};
                bus.total_byte_size <= bus.total_byte_size + {28'd0, wr_nb};
            end
        end
    end
endmodule

// File: doc/sb_packer.md
# sb_packer

Receiving end of the `sb_*` set-bit interface driven by the header writers (frame header, matrix, picture header, slice size table, slice header). It appends variable-length MSB-first bit fields into a big-endian byte stream and issues byte-addressed 64-bit writes to the output buffer. It also maintains the running byte count that feeds back to the header sequencer as `set_bit_total_byte_size`.

## Interface
Parameters:
- `BASE_ADDR`, 0: byte address of the first stream byte.

Ports:
- `clock` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `sb_enable` in 1: append field this cycle.
- `sb_val` in 64: field value; the low `sb_size_of_bit` bits are significant.
- `sb_size_of_bit` in 64: field length in bits. Legal range is 0..64; only bits [6:0] are examined.
- `sb_flush` in 1: pad the stream to a byte boundary and emit all pending bits.
- `wr_en` out 1: write strobe.
- `wr_addr` out 32: byte address of `wr_data[63:56]`. May be unaligned.
- `wr_data` out 64: stream bytes; the first byte is in [63:56].
- `wr_byte_en` out 8: bit 7 enables [63:56], continuing down to bit 0 for [7:0]. Enables are contiguous from bit 7.
- `total_byte_size` out 32: bytes written since reset.
- `busy` out 1: high while a flush tail is draining.
- `err` out 1: sticky protocol-error flag.

## Operation
- Accumulator: holds `n` pending bits, left-justified, with 0 ≤ `n` ≤ 63 between cycles. Field bits are appended MSB-first, and bits of `sb_val` above `sb_size_of_bit` are ignored.
- States:
  - RUN: normal operation; the reset state.
  - TAIL: draining the remainder of a flush.
- RUN, per cycle:
  - If `sb_enable` is high, `m = n + s`, where `s` = min(`sb_size_of_bit[6:0]`, 64). If the field is greater than 64, set `err` and use 64.
  - If `m` ≥ 64: write the top 64 bits with `wr_byte_en`=8'hFF; `n` ← `m`−64.
  - If `sb_flush` is high, it applies after the append in the same cycle. The remainder `r` (bits left after any full-word write) is zero-padded to ceil(`r`/8) bytes.
    - No full word was written and `r` > 0: write the padded bytes this cycle.
    - A full word was also written and `r` > 0: go to TAIL.
    - `r` = 0: no extra write.
  - After a flush, `n` ← 0.
  - `sb_enable`=0 with `sb_size_of_bit` nonzero is ignored. `sb_enable` with size 0 is a no-op append.
- TAIL:
  - Write the padded remainder, then return to RUN.
  - Any `sb_enable` or `sb_flush` seen in TAIL is dropped and sets `err`.
- Addressing: `wr_addr` starts at `BASE_ADDR`. After each write it advances by popcount(`wr_byte_en`), so the byte stream has no gaps.
- `total_byte_size`: advances by the same byte count, updated in the same cycle as the write. It wraps modulo 2^32.
- `err`: cleared only by reset.

## Timing
- All outputs are registered. A write caused by inputs sampled at edge k is visible after edge k, for exactly one cycle.
- A flush tail write appears one cycle after the full-word write. `busy` is high for exactly that cycle.
- Sustained throughput: one 64-bit field per cycle with no stall.
- Reset values: `wr_en`=0, `wr_addr`=`BASE_ADDR`, `wr_data`=0, `wr_byte_en`=0, `total_byte_size`=0, `busy`=0, `err`=0, state RUN, `n`=0.
- Reset asserted mid-stream: pending bits and any TAIL write are discarded. No write is emitted.
- Bytes in `wr_data` that are not enabled are driven 0.
- Padding bits are 0.

## Test plan
- Field 32'hA5A5_1234 (32 bits), then 0x5 (3 bits) with flush:
  - One write at `BASE_ADDR`: data 64'hA5A5_1234_A000_0000, byte_en 8'hF8.
  - `total_byte_size`=5.
- Sixteen 8-bit fields 0x00..0x0F on consecutive cycles, then flush:
  - Writes 64'h0001..07, then 64'h0809..0F, both with byte_en FF.
  - Addresses 0, 8; no flush write; total=16.
- 63 bits of ones, then 64 bits of ones with flush:
  - Cycle 1: full-word write FF×8.
  - Next cycle (`busy`=1): 64'hFFFF_FFFF_FFFF_FFFE with byte_en FF.
  - total=16.
- Flush of 1 bit (value 1) at `BASE_ADDR`, then 8-bit 0x3C with flush:
  - Writes 64'h8000… at `BASE_ADDR`, byte_en 8'h80.
  - Then 64'h3C00… at `BASE_ADDR`+1, byte_en 8'h80; total=2.
- Flush in TAIL:
  - `err`=1; the TAIL write is still correct.
  - Likewise, `sb_size_of_bit`=100 sets `err` and is treated as 64.
- Reset asserted between an append of 20 bits and its flush:
  - No write; all outputs return to reset values.
  - The next flush with no data produces no write.
